// File: rtl/relay_alu_pkg.sv
// Shared definitions for the relay-computer ALU units: datapath width and
// the sequencing states used by the bit-serial arithmetic blocks.
package relay_alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } sub_state_e;

endpackage

// File: rtl/subtractor_block.sv
// One-bit full subtractor: diff = b - c - borrow_in, with the borrow chain
// that mirrors the adder unit's carry chain.
module subtractor_block (
  input  logic b_bit,
  input  logic c_bit,
  input  logic borrow_in,
  output logic diff_bit,
  output logic borrow_out
);

  assign diff_bit   = b_bit ^ c_bit ^ borrow_in;
  assign borrow_out = (~b_bit & c_bit) | (~(b_bit ^ c_bit) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial B - C, LSB first, one bit step followed by SETTLE_CYCLES idle
// cycles per bit to emulate relay switching time.
module serial_subtractor
  import relay_alu_pkg::*;
#(
  parameter int WIDTH         = ALU_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] b_val,
  input  logic [WIDTH-1:0] c_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             sign
);

  // Handshake: start is sampled only while IDLE (ignored otherwise, never
  // queued); busy rises the cycle after acceptance; done is a one-cycle pulse
  // in the same cycle busy falls, with diff and flags valid from then on.

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [IW-1:0] IDX_LAST    = IW'(WIDTH - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             bit_diff;
  logic             bit_borrow;

  subtractor_block u_sub (
    .b_bit      (b_q[idx_q]),
    .c_bit      (c_q[idx_q]),
    .borrow_in  (br_q),
    .diff_bit   (bit_diff),
    .borrow_out (bit_borrow)
  );

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    c_d      = c_q;
    res_d    = res_q;
    br_d     = br_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    done_d   = 1'b0;
    // Output flops lag the state by one cycle, giving the extra result cycle.
    busy_d   = (state_q == STEP) || (state_q == SETTLE);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          b_d     = b_val;
          c_d     = c_val;
          res_d   = '0;
          br_d    = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = STEP;
        end
      end
      STEP: begin
        res_d[idx_q] = bit_diff;
        br_d         = bit_borrow;
        if (SETTLE_CYCLES > 0) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = STEP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        diff_d   = res_q;
        borrow_d = br_q;
        zero_d   = (res_q == '0);
        sign_d   = res_q[WIDTH-1];
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      b_q      <= '0;
      c_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      c_q      <= c_d;
      res_q    <= res_d;
      br_q     <= br_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign zero       = zero_q;
  assign sign       = sign_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: default settle (2) and zero-settle instances,
// checked against an arithmetic model of B - C and the latency formula.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start_a, start_z;
  logic [W-1:0] b_a, c_a, b_z, c_z;
  logic         busy_a, done_a, borrow_a, zero_a, sign_a;
  logic         busy_z, done_z, borrow_z, zero_z, sign_z;
  logic [W-1:0] diff_a, diff_z;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start_a), .b_val(b_a), .c_val(c_a),
    .busy(busy_a), .done(done_a), .diff(diff_a), .borrow_out(borrow_a),
    .zero(zero_a), .sign(sign_a)
  );

  serial_subtractor #(.WIDTH(W), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start_z), .b_val(b_z), .c_val(c_z),
    .busy(busy_z), .done(done_z), .diff(diff_z), .borrow_out(borrow_z),
    .zero(zero_z), .sign(sign_z)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // sel=1 selects the zero-settle instance
  task automatic sample(input bit sel, output logic bsy, output logic dn,
                        output logic [W-1:0] df, output logic br,
                        output logic z, output logic s);
    if (sel) begin
      bsy = busy_z; dn = done_z; df = diff_z; br = borrow_z; z = zero_z; s = sign_z;
    end else begin
      bsy = busy_a; dn = done_a; df = diff_a; br = borrow_a; z = zero_a; s = sign_a;
    end
  endtask

  task automatic drive(input bit sel, input logic st, input logic [W-1:0] b, input logic [W-1:0] c);
    if (sel) begin start_z = st; b_z = b; c_z = c; end
    else     begin start_a = st; b_a = b; c_a = c; end
  endtask

  task automatic set_start(input bit sel, input logic st);
    if (sel) start_z = st; else start_a = st;
  endtask

  task automatic scramble(input bit sel);
    if (sel) begin b_z = W'($urandom); c_z = W'($urandom); end
    else     begin b_a = W'($urandom); c_a = W'($urandom); end
  endtask

  task automatic check_all_zero(input bit sel, input string tag);
    logic bsy, dn, br, z, s;
    logic [W-1:0] df;
    sample(sel, bsy, dn, df, br, z, s);
    check({tag, "_busy"}, 32'(bsy), 32'd0);
    check({tag, "_done"}, 32'(dn), 32'd0);
    check({tag, "_diff"}, 32'(df), 32'd0);
    check({tag, "_borrow"}, 32'(br), 32'd0);
    check({tag, "_zero"}, 32'(z), 32'd0);
    check({tag, "_sign"}, 32'(s), 32'd0);
  endtask

  // Driver + scoreboard for one operation. hold keeps start asserted for the
  // whole operation; operands are scrambled every cycle after acceptance.
  task automatic run_op(input bit sel, input logic [W-1:0] b, input logic [W-1:0] c,
                        input bit hold, input string tag);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_diff;
    logic         exp_borrow;
    int           lat, n, settle;
    bit           got;
    logic         bsy, dn, br, z, s;
    logic [W-1:0] df;

    settle     = sel ? 0 : 2;
    lat        = W * (1 + settle) + 1;
    exp_diff   = W'((int'(b) - int'(c) + 256) % 256);
    exp_borrow = (b < c);
    exp_q.push_back(exp_diff);

    @(negedge clk);
    drive(sel, 1'b1, b, c);
    @(posedge clk); #1;
    if (!hold) set_start(sel, 1'b0);
    sample(sel, bsy, dn, df, br, z, s);
    check({tag, "_busy_at_accept"}, 32'(bsy), 32'd0);

    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      scramble(sel);
      sample(sel, bsy, dn, df, br, z, s);
      if (dn) got = 1'b1;
      else if (n == 1) check({tag, "_busy_next"}, 32'(bsy), 32'd1);
    end
    set_start(sel, 1'b0);

    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_busy_fall"}, 32'(bsy), 32'd0);
    check({tag, "_diff"}, 32'(df), 32'(exp_q.pop_front()));
    check({tag, "_borrow"}, 32'(br), 32'(exp_borrow));
    check({tag, "_zero"}, 32'(z), 32'(exp_diff == '0));
    check({tag, "_sign"}, 32'(s), 32'(exp_diff[W-1]));

    @(posedge clk); #1;
    sample(sel, bsy, dn, df, br, z, s);
    check({tag, "_done_pulse"}, 32'(dn), 32'd0);
    check({tag, "_diff_hold"}, 32'(df), 32'(exp_diff));
    if (hold) check({tag, "_no_requeue"}, 32'(bsy), 32'd0);
  endtask

  initial begin
    int dn_cnt;
    logic [W-1:0] rb, rc;

    reset = 1'b1;
    start_a = 1'b0; b_a = '0; c_a = '0;
    start_z = 1'b0; b_z = '0; c_z = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero(1'b0, "rst_a");
    check_all_zero(1'b1, "rst_z");
    @(negedge clk);
    reset = 1'b0;

    run_op(1'b0, 8'h05, 8'h03, 1'b0, "t_05_03");
    run_op(1'b0, 8'h03, 8'h05, 1'b0, "t_03_05");
    run_op(1'b0, 8'h00, 8'h01, 1'b0, "t_ripple");
    run_op(1'b0, 8'h80, 8'h80, 1'b0, "t_80_80");
    run_op(1'b0, 8'hFF, 8'h00, 1'b0, "t_ff_00");

    // start held through busy and the final state cycle: exactly one done
    run_op(1'b0, 8'h5C, 8'hC5, 1'b1, "t_hold");
    dn_cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done_a) dn_cnt++;
    end
    check("hold_extra_done", 32'(dn_cnt), 32'd0);
    run_op(1'b0, 8'h21, 8'h12, 1'b0, "t_after_hold");

    for (int i = 0; i < 6; i++) begin
      rb = W'($urandom); rc = W'($urandom);
      run_op(1'b0, rb, rc, 1'b0, "rand_a");
    end

    // reset in the middle of an operation
    run_op(1'b0, 8'h37, 8'h12, 1'b0, "t_pre_rst");
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h99, 8'h11);
    @(posedge clk); #1;
    set_start(1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero(1'b0, "mid_rst");
    dn_cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done_a || busy_a) dn_cnt++;
    end
    check("mid_rst_quiet", 32'(dn_cnt), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    run_op(1'b0, 8'h10, 8'h01, 1'b0, "t_after_rst");

    // zero-settle instance
    run_op(1'b1, 8'hA5, 8'h5A, 1'b0, "z_a5_5a");
    run_op(1'b1, 8'h00, 8'h01, 1'b0, "z_ripple");
    run_op(1'b1, 8'h80, 8'h80, 1'b0, "z_80_80");
    for (int i = 0; i < 6; i++) begin
      rb = W'($urandom); rc = W'($urandom_range(255, 0));
      run_op(1'b1, rb, rc, 1'b0, "rand_z");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
